// File: rtl/issue_pkg.sv
// issue_pkg: instruction field map, opcode classes and scheduler state encoding
package issue_pkg;
  localparam int NUM_REGS = 8;
  localparam int REG_W = 3;
  localparam int INSTR_W = 16;
  localparam int OP_LSB = 12;
  localparam int RD_LSB = 9;
  localparam int RS1_LSB = 6;
  localparam int IMM_BIT = 5;
  localparam int RS2_LSB = 2;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_BR_LO = 4'hC;
  localparam logic [3:0] OP_BR_HI = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;
  typedef enum logic [1:0] {RUN, BR_WAIT, HALTED} state_t;
  function automatic logic [3:0] opc(logic [INSTR_W-1:0] i);
    return i[OP_LSB+:4];
  endfunction
  function automatic logic [REG_W-1:0] rd_of(logic [INSTR_W-1:0] i);
    return i[RD_LSB+:REG_W];
  endfunction
  function automatic logic [REG_W-1:0] rs1_of(logic [INSTR_W-1:0] i);
    return i[RS1_LSB+:REG_W];
  endfunction
  function automatic logic [REG_W-1:0] rs2_of(logic [INSTR_W-1:0] i);
    return i[RS2_LSB+:REG_W];
  endfunction
  function automatic logic is_alu(logic [INSTR_W-1:0] i);
    return opc(i) != OP_NOP && opc(i) < OP_LOAD;
  endfunction
  function automatic logic is_branch(logic [INSTR_W-1:0] i);
    return opc(i) >= OP_BR_LO && opc(i) <= OP_BR_HI;
  endfunction
  function automatic logic is_halt(logic [INSTR_W-1:0] i);
    return opc(i) == OP_HALT;
  endfunction
  function automatic logic writes(logic [INSTR_W-1:0] i);
    return is_alu(i) || opc(i) == OP_LOAD;
  endfunction
  function automatic logic reads_rs1(logic [INSTR_W-1:0] i);
    return is_alu(i) || opc(i) == OP_LOAD || opc(i) == OP_STORE || is_branch(i);
  endfunction
  function automatic logic reads_rs2(logic [INSTR_W-1:0] i);
    return is_alu(i) && !i[IMM_BIT];
  endfunction
  function automatic logic reads_rd(logic [INSTR_W-1:0] i);
    return opc(i) == OP_STORE || is_branch(i);
  endfunction
  function automatic logic reads_reg(logic [INSTR_W-1:0] i, logic [REG_W-1:0] r);
    return (reads_rs1(i) && rs1_of(i) == r) || (reads_rs2(i) && rs2_of(i) == r) ||
           (reads_rd(i) && rd_of(i) == r);
  endfunction
  function automatic logic hazard(logic [INSTR_W-1:0] i, logic [NUM_REGS-1:0] b);
    return (reads_rs1(i) && b[rs1_of(i)]) || (reads_rs2(i) && b[rs2_of(i)]) ||
           ((reads_rd(i) || writes(i)) && b[rd_of(i)]);
  endfunction
endpackage

// File: rtl/issue_scheduler_scoreboard.sv
// scoreboard: per-register busy bits, set on issue, cleared on writeback, set wins
module scoreboard
  import issue_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en0,
  input  logic [REG_W-1:0]    set_rd0,
  input  logic                set_en1,
  input  logic [REG_W-1:0]    set_rd1,
  input  logic                clr_en0,
  input  logic [REG_W-1:0]    clr_rd0,
  input  logic                clr_en1,
  input  logic [REG_W-1:0]    clr_rd1,
  output logic [NUM_REGS-1:0] busy
);
  logic [NUM_REGS-1:0] set_m, clr_m;
  assign set_m = (NUM_REGS'(set_en0) << set_rd0) | (NUM_REGS'(set_en1) << set_rd1);
  assign clr_m = (NUM_REGS'(clr_en0) << clr_rd0) | (NUM_REGS'(clr_en1) << clr_rd1);
  // apply clears first so a same-cycle set of the same register survives
  always_ff @(posedge clk or negedge reset)
    if (!reset) busy <= '0;
    else busy <= (busy & ~clr_m) | set_m;
endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: dual-issue in-order front end with scoreboard hazards and branch serialisation
module issue_scheduler
  import issue_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [INSTR_W-1:0]  in_instr0,
  input  logic [INSTR_W-1:0]  in_instr1,
  output logic                in_ready,
  input  logic                stall,
  input  logic                wb_en0,
  input  logic                wb_en1,
  input  logic [REG_W-1:0]    wb_rd0,
  input  logic [REG_W-1:0]    wb_rd1,
  input  logic                branch_resolve,
  input  logic                is_branch_taken,
  output logic                issue_valid0,
  output logic                issue_valid1,
  output logic [INSTR_W-1:0]  issue_instr0,
  output logic [INSTR_W-1:0]  issue_instr1,
  output logic [NUM_REGS-1:0] busy,
  output logic                halted
);
  state_t state, state_nx;
  logic [INSTR_W-1:0] b0, b1;
  logic b0v, b1v, live, run, go0, go1, pair_ok, accept, flush;
  assign run = live && state == RUN && !stall;
  assign go0 = run && b0v && !hazard(b0, busy);
  assign pair_ok = !is_branch(b0) && !is_halt(b0) && !is_branch(b1) && !is_halt(b1) &&
                   !(writes(b0) && (reads_reg(b1, rd_of(b0)) || (writes(b1) && rd_of(b1) == rd_of(b0))));
  assign go1 = go0 && b1v && pair_ok && !hazard(b1, busy);
  assign in_ready = run && (!b0v || go0) && (!b1v || go1);
  assign accept = in_valid && in_ready;
  assign flush = state == BR_WAIT && !stall && branch_resolve && is_branch_taken;
  assign halted = state == HALTED;
  scoreboard u_sb (
    .clk(clk), .reset(reset),
    .set_en0(go0 && writes(b0)), .set_rd0(rd_of(b0)),
    .set_en1(go1 && writes(b1)), .set_rd1(rd_of(b1)),
    .clr_en0(wb_en0), .clr_rd0(wb_rd0),
    .clr_en1(wb_en1), .clr_rd1(wb_rd1),
    .busy(busy)
  );
  // next state: an issued branch waits for resolution, an issued HALT parks forever
  always_comb begin
    state_nx = stall ? state :
               state == BR_WAIT ? (branch_resolve ? RUN : BR_WAIT) :
               go0 && is_branch(b0) ? BR_WAIT :
               go0 && is_halt(b0) ? HALTED : state;
  end
  // buffer, issue registers and state; everything holds while stalled
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= RUN;
      live <= 1'b0;
      b0 <= '0;
      b1 <= '0;
      b0v <= 1'b0;
      b1v <= 1'b0;
      issue_valid0 <= 1'b0;
      issue_valid1 <= 1'b0;
      issue_instr0 <= '0;
      issue_instr1 <= '0;
    end else begin
      state <= state_nx;
      live <= 1'b1;
      if (accept) begin
        b0 <= in_instr0;
        b1 <= in_instr1;
        b0v <= 1'b1;
        b1v <= 1'b1;
      end else if (go0 && b1v && !go1) begin
        b0 <= b1;
        b1v <= 1'b0;
      end else if (go0 || flush) begin
        b0v <= 1'b0;
        b1v <= 1'b0;
      end
      if (!stall) begin
        issue_valid0 <= go0;
        issue_valid1 <= go1;
        issue_instr0 <= go0 ? b0 : '0;
        issue_instr1 <= go1 ? b1 : '0;
      end
    end
endmodule
